// File: rtl/hmmm_mem.sv
// Unified 256 x 15-bit memory for the HMMM core: combinational core reads, clocked core
// writes, and a 24-bit serial loader/readback port with a one-entry deferred-write buffer.
module hmmm_mem #(
    parameter int WIDTH  = 15,
    parameter int ADR_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [ADR_W-1:0] Adr,
    inout  wire  [WIDTH-1:0] MemData,
    input  logic             sen,
    input  logic             sdi,
    output logic             sdo,
    output logic             ld_busy,
    output logic             ld_err
);

    localparam int DEPTH      = 2 ** ADR_W;
    localparam int FRAME_BITS = 1 + ADR_W + WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    // cnt_q holds the number of frame edges already taken, so edge k sees cnt_q == k-1
    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(ADR_W);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, HDR, RDATA, WDATA, DONE} state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_q, cmd_d;
    logic [ADR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             err_q, err_d;
    logic             pend_q, pend_d;
    logic [ADR_W-1:0] pend_addr_q, pend_addr_d;
    logic [WIDTH-1:0] pend_data_q, pend_data_d;

    logic             commit;
    logic             flush;
    logic             abort;
    logic [ADR_W-1:0] addr_next;
    logic [WIDTH-1:0] commit_word;
    logic             unused_hi;

    assign MemData   = MemWrite ? {WIDTH{1'bz}} : mem_q[Adr];
    assign unused_hi = ^MemData[WIDTH-1:DATA_W];

    assign sdo     = (state_q == RDATA) & shreg_q[WIDTH-1];
    assign ld_busy = (state_q != IDLE) | pend_q;
    assign ld_err  = err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        shreg_d     = shreg_q;
        err_d       = err_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        commit      = 1'b0;
        abort       = 1'b0;
        addr_next   = {addr_q[ADR_W-2:0], sdi};
        commit_word = {shreg_q[WIDTH-2:0], sdi};
        flush       = pend_q & ~MemWrite;

        if (flush) pend_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sen) begin
                    state_d = HDR;
                    cnt_d   = CNT_W'(1);
                    cmd_d   = sdi;
                    err_d   = 1'b0;
                end
            end
            HDR: begin
                if (!sen) begin
                    abort = 1'b1;
                end else begin
                    addr_d = addr_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == HDR_LAST) begin
                        if (cmd_q) begin
                            state_d = WDATA;
                        end else begin
                            state_d = RDATA;
                            shreg_d = mem_q[addr_next];
                        end
                    end
                end
            end
            RDATA: begin
                if (!sen) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == FRAME_LAST) state_d = DONE;
                    else shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end
            end
            WDATA: begin
                if (!sen) begin
                    abort = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shreg_d = commit_word;
                    if (cnt_q == FRAME_LAST) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!sen) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end

        // The core owns the array on a write cycle; the loader word waits in the buffer,
        // displacing (and flagging) any entry that is still waiting.
        if (commit && MemWrite) begin
            pend_d      = 1'b1;
            pend_addr_d = addr_q;
            pend_data_d = commit_word;
            if (pend_q) err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= 1'b0;
            addr_q      <= '0;
            shreg_q     <= '0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            shreg_q     <= shreg_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain storage and survives a reset pulse.
    always_ff @(posedge clk) begin
        if (MemWrite) begin
            mem_q[Adr] <= {{(WIDTH-DATA_W){1'b0}}, MemData[DATA_W-1:0]};
        end else begin
            // A flush and a fresh commit may land on the same edge; the newer word wins.
            if (flush)  mem_q[pend_addr_q] <= pend_data_q;
            if (commit) mem_q[addr_q]      <= commit_word;
        end
    end

endmodule

// File: tb/tb_hmmm_mem.sv
// Scoreboard bench for hmmm_mem: stimulus drives the core bus and loader frames and queues
// expected words from an array-level model; a monitor decodes readback and bus reads.
module tb_hmmm_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [7:0]  adr;
    logic [14:0] bus_drv;
    wire  [14:0] mem_data;
    logic        sen;
    logic        sdi;
    logic        sdo;
    logic        ld_busy;
    logic        ld_err;

    assign mem_data = mem_write ? bus_drv : 15'bz;

    always #5 clk = ~clk;

    hmmm_mem dut (
        .clk     (clk),
        .reset   (reset),
        .MemWrite(mem_write),
        .Adr     (adr),
        .MemData (mem_data),
        .sen     (sen),
        .sdi     (sdi),
        .sdo     (sdo),
        .ld_busy (ld_busy),
        .ld_err  (ld_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: array contents, deferred loader write, sticky error.
    logic [14:0] mm [256];
    logic        pend;
    logic [7:0]  pa;
    logic [14:0] pd;
    logic        exp_err;

    logic [14:0] exp_rd_q [$];
    logic [14:0] bus_q [$];
    logic        bus_chk;

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: decodes read frames from the loader pins and core bus reads.
    int          mon_cnt;
    logic        mon_cmd;
    logic [14:0] mon_word;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mon_cnt <= 0;
        end else if (sen) begin
            if (mon_cnt == 0) mon_cmd <= sdi;
            if (mon_cnt < 30) mon_cnt <= mon_cnt + 1;
        end else begin
            mon_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (reset && mon_cmd == 1'b0 && mon_cnt >= 9 && mon_cnt <= 23) begin
            mon_word = {mon_word[13:0], sdo};
            if (mon_cnt == 23) begin
                if (exp_rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL readback: got %h with no expected word queued", mon_word);
                end else begin
                    check("readback", mon_word, exp_rd_q.pop_front());
                end
            end
        end
        if (bus_chk) begin
            if (bus_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL core_read: got %h with no expected word queued", mem_data);
            end else begin
                check("core_read", mem_data, bus_q.pop_front());
            end
        end
    end

    // Model of one clock edge with no loader commit.
    task automatic model_edge(input logic mw, input logic [7:0] a, input logic [14:0] d);
        if (mw) begin
            mm[a] = {7'b0, d[7:0]};
        end else if (pend) begin
            mm[pa] = pd;
            pend   = 1'b0;
        end
    endtask

    // Model of the edge that completes a loader write.
    task automatic model_commit(input logic [7:0] la, input logic [14:0] lw, input logic mw,
                                input logic [7:0] ca, input logic [14:0] cd);
        if (!mw) begin
            if (pend) mm[pa] = pd;
            pend   = 1'b0;
            mm[la] = lw;
        end else begin
            mm[ca] = {7'b0, cd[7:0]};
            if (pend) exp_err = 1'b1;
            pend = 1'b1;
            pa   = la;
            pd   = lw;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends nbits of a frame, then one edge with sen low. The core bus holds mw/cadr/cdat
    // on every edge of the frame, including the trailing one.
    task automatic send_frame(input logic cmd, input logic [7:0] a, input logic [14:0] d,
                              input int nbits, input logic mw,
                              input logic [7:0] cadr, input logic [14:0] cdat);
        logic [23:0] bits;
        bits      = {cmd, a, d};
        mem_write = mw;
        adr       = cadr;
        bus_drv   = cdat;
        for (int i = 0; i < nbits; i++) begin
            sen = 1'b1;
            sdi = bits[23-i];
            if (i == 0) exp_err = 1'b0;
            if (i == 8 && !cmd) exp_rd_q.push_back(mm[a]);
            if (i == 23 && cmd) model_commit(a, d, mw, cadr, cdat);
            else model_edge(mw, cadr, cdat);
            step();
        end
        sen = 1'b0;
        sdi = 1'b0;
        if (nbits > 0 && nbits < 24) exp_err = 1'b1;
        model_edge(mw, cadr, cdat);
        step();
        mem_write = 1'b0;
    endtask

    task automatic lwrite(input logic [7:0] a, input logic [14:0] d);
        send_frame(1'b1, a, d, 24, 1'b0, 8'h00, 15'h0);
    endtask

    task automatic lread(input logic [7:0] a);
        send_frame(1'b0, a, 15'h0, 24, 1'b0, 8'h00, 15'h0);
    endtask

    task automatic core_write(input logic [7:0] a, input logic [14:0] d);
        mem_write = 1'b1;
        adr       = a;
        bus_drv   = d;
        model_edge(1'b1, a, d);
        step();
        mem_write = 1'b0;
    endtask

    task automatic core_read(input logic [7:0] a);
        mem_write = 1'b0;
        adr       = a;
        bus_q.push_back(mm[a]);
        bus_chk = 1'b1;
        model_edge(1'b0, a, 15'h0);
        step();
        bus_chk = 1'b0;
    endtask

    task automatic status(input string tag);
        check({tag, ".ld_busy"}, ld_busy, pend);
        check({tag, ".ld_err"}, ld_err, exp_err);
        check({tag, ".sdo"}, sdo, 1'b0);
    endtask

    initial begin
        logic [23:0] bits;
        reset     = 1'b1;
        mem_write = 1'b0;
        adr       = 8'h00;
        bus_drv   = 15'h0;
        sen       = 1'b0;
        sdi       = 1'b0;
        bus_chk   = 1'b0;
        pend      = 1'b0;
        pa        = 8'h00;
        pd        = 15'h0;
        exp_err   = 1'b0;
        #1 reset = 1'b0;
        #8;
        status("reset");
        @(negedge clk) reset = 1'b1;
        step();

        // Loader write, then core read of the same word.
        lwrite(8'h05, 15'h1234);
        core_read(8'h05);
        status("lwrite");

        // Loader readback of a known word.
        lwrite(8'h10, 15'h7ABC);
        lread(8'h10);
        status("lread");

        // Core write ignores bus bits [14:8].
        core_write(8'h20, 15'h7FA5);
        lread(8'h20);

        // Collision: core write on the commit edge defers the loader word.
        lwrite(8'h30, 15'h0000);
        lwrite(8'h31, 15'h0000);
        send_frame(1'b1, 8'h30, 15'h0042, 24, 1'b1, 8'h31, 15'h0055);
        status("collide_pending");
        core_read(8'h30);
        status("collide_flushed");
        core_read(8'h30);
        core_read(8'h31);

        // Second collision while the buffer is full drops the older entry.
        lwrite(8'h32, 15'h0AAA);
        send_frame(1'b1, 8'h32, 15'h0111, 24, 1'b1, 8'h33, 15'h0066);
        send_frame(1'b1, 8'h34, 15'h0222, 24, 1'b1, 8'h33, 15'h0077);
        status("drop");
        core_read(8'h32);
        core_read(8'h34);
        status("drop_flushed");

        // Abort mid-write leaves the word intact and raises the sticky error.
        lwrite(8'h40, 15'h0001);
        send_frame(1'b1, 8'h40, 15'h3333, 15, 1'b0, 8'h00, 15'h0);
        status("abort");
        core_read(8'h40);
        lread(8'h40);
        status("abort_cleared");

        // Reset during a write frame: nothing committed, port back to idle.
        lwrite(8'h50, 15'h0ABC);
        bits = {1'b1, 8'h50, 15'h1111};
        for (int i = 0; i < 11; i++) begin
            sen = 1'b1;
            sdi = bits[23-i];
            model_edge(1'b0, adr, bus_drv);
            step();
        end
        #2 reset = 1'b0;
        sen     = 1'b0;
        sdi     = 1'b0;
        pend    = 1'b0;
        exp_err = 1'b0;
        #1;
        status("mid_reset");
        @(negedge clk) reset = 1'b1;
        step();
        core_read(8'h50);
        lwrite(8'h50, 15'h2468);
        lread(8'h50);

        // Randomized mix over a preloaded window.
        for (int a = 8'h60; a < 8'h70; a++) lwrite(8'(a), 15'($urandom_range(0, 32767)));
        for (int n = 0; n < 60; n++) begin
            logic [7:0]  ra, ca;
            logic [14:0] rd, cd;
            logic        mw;
            ra = 8'(8'h60 + $urandom_range(0, 15));
            ca = 8'(8'h60 + $urandom_range(0, 15));
            rd = 15'($urandom_range(0, 32767));
            cd = 15'($urandom_range(0, 32767));
            mw = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0: send_frame(1'b1, ra, rd, 24, mw, ca, cd);
                1: send_frame(1'b0, ra, 15'h0, 24, mw, ca, cd);
                2: core_write(ra, cd);
                3: core_read(ra);
                default: send_frame(1'b1, ra, rd, $urandom_range(1, 23), mw, ca, cd);
            endcase
            status("random");
        end

        core_read(8'h61);
        repeat (3) step();
        check("readback_queue_drained", 15'(exp_rd_q.size()), 15'd0);
        check("bus_queue_drained", 15'(bus_q.size()), 15'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
